// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard between ID and WB.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [ADDR_W:0]     inc;
  logic [ADDR_W:0]     dec;

  // Address 0 and the unimplemented tail of the address space are never stored.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Later ports are assigned last, so the highest-index port wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && in_range(waddr[k*ADDR_W +: ADDR_W]))
          regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // A new issue supersedes any writeback to the same register in that cycle.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && in_range(waddr[k*ADDR_W +: ADDR_W]))
        clr_mask[waddr[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (issue_valid && in_range(issue_addr))
      set_mask[issue_addr] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
    inc      = (ADDR_W+1)'($countones(set_mask & ~busy));
    dec      = (ADDR_W+1)'($countones(busy & clr_mask & ~set_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + inc - dec;
    end
  end

  always_comb begin : read_ports
    logic [ADDR_W-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      if (!rst && re[i] && in_range(ra)) begin
        rdata[i*DATA_W +: DATA_W] = regs[ra];
        rbusy[i]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
        // A forwarded result is no longer pending unless re-issued this cycle.
        for (int k = 0; k < NUM_WR; k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) begin
            rdata[i*DATA_W +: DATA_W] = wdata[k*DATA_W +: DATA_W];
            rbusy[i]                  = issue_valid && (issue_addr == ra);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 3;
  localparam int NUM_WR   = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_WR-1:0]        we = '0;
  logic [NUM_WR*ADDR_W-1:0] waddr = '0;
  logic [NUM_WR*DATA_W-1:0] wdata = '0;
  logic [NUM_RD-1:0]        re = '0;
  logic [NUM_RD*ADDR_W-1:0] raddr = '0;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     issue_valid = 1'b0;
  logic [ADDR_W-1:0]        issue_addr = '0;
  logic                     flush = 1'b0;
  logic [ADDR_W:0]          busy_cnt;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  regfile_mp #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rd(input int i);
    return rdata[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rb(input int i);
    return DATA_W'(rbusy[i]);
  endfunction

  function automatic logic [DATA_W-1:0] cnt();
    return DATA_W'(busy_cnt);
  endfunction

  task automatic expectVal(input string tag, input logic [DATA_W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [DATA_W-1:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %h, want a queued expectation", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: got %h, want %h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic idle();
    we          = '0;
    re          = '0;
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic setWrite(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we[k]                     = 1'b1;
    waddr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic setRead(input int i, input logic [ADDR_W-1:0] a);
    re[i]                     = 1'b1;
    raddr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] regfile_mp directed sequence");
    #1 rst = 1'b1;
    #2;
    expectVal("reset_busy_cnt", '0);
    checkOutput(cnt());
    expectVal("reset_rdata0", '0);
    checkOutput(rd(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Writes to x0 must not stick.
    idle();
    setWrite(0, 0, 32'hDEADBEEF);
    applyStimulus();
    idle();
    setRead(0, 0);
    expectVal("x0_reads_zero", '0);
    #2 checkOutput(rd(0));

    // x5 visible on every read port.
    setWrite(0, 5, 32'h1234);
    applyStimulus();
    idle();
    for (int i = 0; i < NUM_RD; i++) begin
      setRead(i, 5);
      expectVal($sformatf("x5_port%0d", i), 32'h1234);
    end
    #2;
    for (int i = 0; i < NUM_RD; i++) checkOutput(rd(i));

    // Disabled read port returns zero even with a valid address.
    re[1] = 1'b0;
    expectVal("re_off_zero", '0);
    #1 checkOutput(rd(1));

    // Same-address write conflict resolves to port 1.
    idle();
    setWrite(0, 7, 32'hAAAA);
    setWrite(1, 7, 32'h5555);
    applyStimulus();
    idle();
    setRead(2, 7);
    expectVal("conflict_x7", 32'h5555);
    #2 checkOutput(rd(2));

    // Same-cycle read of a register being written.
    idle();
    setWrite(0, 9, 32'h1111);
    applyStimulus();
    idle();
    setWrite(1, 9, 32'hCAFE);
    setRead(0, 9);
`ifdef REGFILE_BYPASS_EN
    expectVal("x9_same_cycle", 32'hCAFE);
`else
    expectVal("x9_same_cycle", 32'h1111);
`endif
    #2 checkOutput(rd(0));
    applyStimulus();
    idle();
    setRead(0, 9);
    expectVal("x9_next_cycle", 32'hCAFE);
    #2 checkOutput(rd(0));

    // Scoreboard: issue x3 then x4.
    idle();
    issue(3);
    applyStimulus();
    issue(4);
    applyStimulus();
    idle();
    expectVal("cnt_after_two_issues", 32'd2);
    #2 checkOutput(cnt());
    setRead(0, 3);
    setRead(1, 5);
    expectVal("rbusy_x3", 32'd1);
    expectVal("rbusy_x5_idle", 32'd0);
    #1;
    checkOutput(rb(0));
    checkOutput(rb(1));

    // Writeback and re-issue of x3 on the same edge keeps it busy.
    idle();
    setWrite(0, 3, 32'h777);
    issue(3);
    applyStimulus();
    idle();
    expectVal("cnt_wb_reissue", 32'd2);
    #1 checkOutput(cnt());
    setRead(0, 3);
    expectVal("rbusy_x3_reissued", 32'd1);
    expectVal("rdata_x3", 32'h777);
    #1;
    checkOutput(rb(0));
    checkOutput(rd(0));

    // Writeback x4 while re-issuing an already busy x3.
    idle();
    setWrite(0, 4, 32'h4444);
    issue(3);
    applyStimulus();
    idle();
    expectVal("cnt_after_wb_x4", 32'd1);
    #1 checkOutput(cnt());
    setRead(0, 4);
    setRead(1, 3);
    expectVal("rbusy_x4_cleared", 32'd0);
    expectVal("rbusy_x3_still", 32'd1);
    #1;
    checkOutput(rb(0));
    checkOutput(rb(1));

    // Flush overrides a same-cycle issue.
    idle();
    issue(4);
    applyStimulus();
    idle();
    expectVal("cnt_before_flush", 32'd2);
    #1 checkOutput(cnt());
    flush = 1'b1;
    issue(8);
    applyStimulus();
    idle();
    expectVal("cnt_after_flush", 32'd0);
    #1 checkOutput(cnt());
    setRead(0, 8);
    setRead(1, 3);
    expectVal("rbusy_x8_flushed", 32'd0);
    expectVal("rbusy_x3_flushed", 32'd0);
    #1;
    checkOutput(rb(0));
    checkOutput(rb(1));

    // Issuing x0 never marks anything busy.
    idle();
    issue(0);
    applyStimulus();
    idle();
    expectVal("cnt_issue_x0", 32'd0);
    #1 checkOutput(cnt());

    // Asynchronous reset mid-cycle with live state.
    issue(10);
    applyStimulus();
    idle();
    setRead(0, 5);
    setRead(1, 7);
    setRead(2, 10);
    expectVal("pre_reset_x5", 32'h1234);
    expectVal("pre_reset_rbusy_x10", 32'd1);
    #1;
    checkOutput(rd(0));
    checkOutput(rb(2));
    rst = 1'b1;
    expectVal("rst_rdata0", '0);
    expectVal("rst_rdata1", '0);
    expectVal("rst_rbusy2", '0);
    expectVal("rst_busy_cnt", '0);
    #1;
    checkOutput(rd(0));
    checkOutput(rd(1));
    checkOutput(rb(2));
    checkOutput(cnt());
    applyStimulus();
    rst = 1'b0;
    setRead(2, 9);
    expectVal("post_reset_x5", '0);
    expectVal("post_reset_x7", '0);
    expectVal("post_reset_x9", '0);
    #2;
    checkOutput(rd(0));
    checkOutput(rd(1));
    checkOutput(rd(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read register file.
- Provides NUM_RD combinational read ports and NUM_WR write ports with a fixed port-priority rule.
- Adds a per-register busy scoreboard: decode marks a destination busy, writeback clears it.
- Sits between the ID stage (reads, issue) and the WB stage (writes).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, packed the same way.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses, packed.
- rdata  out  NUM_RD*DATA_W  read data, packed.
- rbusy  out  NUM_RD  busy flag of the register addressed by each read port.
- issue_valid  in  1  decode issues an instruction that writes issue_addr.
- issue_addr  in  ADDR_W  destination of the issued instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset: rst is asynchronous active-high; clk is the single clock.
  - While rst is high: all registers are 0, all busy bits are 0, busy_cnt is 0, every rdata is 0 and every rbusy is 0.
  - Deassertion takes effect at the next clk edge.
- Writes (posedge clk):
  - Port k with we[k]=1 writes wdata_k to regs[waddr_k].
  - Writes to address 0, or to addresses >= NUM_REGS, are ignored.
  - Two ports writing the same address in one cycle: the highest-index port wins.
- Reads (combinational, zero latency), evaluated in this priority order:
  1. rst high: rdata_i = 0.
  2. raddr_i == 0 or raddr_i >= NUM_REGS: rdata_i = 0.
  3. re[i]=0: rdata_i = 0.
  4. Bypass: see Optional Feature.
  5. Otherwise: rdata_i = regs[raddr_i].
- Scoreboard: busy[NUM_REGS-1:0]; busy[0] is always 0.
  - Clear: any write port with we=1 to address a clears busy[a] at the edge.
  - Set: issue_valid=1 with issue_addr != 0 sets busy[issue_addr] at the edge.
  - Same-edge set and clear of one address: set wins, because the new producer supersedes the old one.
  - flush=1 clears all busy bits at the edge and overrides issue_valid in that cycle.
  - Setting a bit that is already busy is idempotent.
  - Clearing a bit that is not busy is a no-op.
- rbusy_i = busy[raddr_i], with these exceptions:
  - rbusy_i = 0 when raddr_i is 0, out of range, or re[i]=0.
  - rbusy_i is also modified by bypass (see Optional Feature).
- busy_cnt:
  - Equals popcount(busy) and updates on the same edge as busy.
  - Implemented as a registered counter using per-cycle set/clear deltas, not a combinational popcount of the next state.
  - Never exceeds NUM_REGS-1.
  - Returns to 0 on flush or rst.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If re[i]=1, raddr_i != 0, and some port k has we[k]=1 with waddr_k == raddr_i in the same cycle, then rdata_i = wdata_k. The highest matching k is used.
  - In that case rbusy_i = 0 unless issue_valid targets the same address in that cycle.
- Not defined:
  - Reads return the stored value until the next edge; no same-cycle forwarding.
  - rbusy_i reflects only the stored busy bit.

Test Plan:
- Reset with all regs written nonzero: assert rst asynchronously mid-cycle -> every rdata=0, rbusy=0 and busy_cnt=0 immediately, and all regs read 0 after release.
- Write x0: we[0]=1, waddr0=0, wdata0=32'hDEADBEEF -> next cycle raddr0=0 reads 0.
- Write x5=32'h1234 then read it on all 3 ports -> all return 32'h1234.
- Write conflict: we=2'b11, waddr0=waddr1=7, wdata0=32'hAAAA, wdata1=32'h5555 -> x7 reads 32'h5555.
- Same-cycle read of x9 while port 1 writes 32'hCAFE to x9:
  - With REGFILE_BYPASS_EN: rdata=32'hCAFE in the same cycle.
  - Without it: rdata shows the old value that cycle and 32'hCAFE next cycle.
- Scoreboard sequence:
  - Issue x3, then x4 -> busy_cnt=2, and rbusy=1 when reading x3.
  - Writeback x3 while issuing x3 in the same cycle -> x3 stays busy, busy_cnt=2.
  - Flush -> busy_cnt=0.
